scs8hd_clkdiv_gate: RTL and testbench

- Programmable, glitch-free clock divider and gate. Sits directly upstream of scs8hd_clkbuf_8 in the clock tree.
- Its output X drives the A pin of a clkbuf_8, which fans the divided clock out to a local domain.
- Produces a 50%-duty clock at an even division of CLK.
- Start, stop and ratio changes happen only on whole-period boundaries, so the downstream buffer never sees a runt pulse.

---
 rtl/scs8hd_clkdiv_gate.sv | 143 ++++++++++++++
 tb/tb_scs8hd_clkdiv_gate.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_clkdiv_gate.sv
// -----------------------------------------------------------------------------
// scs8hd_clkdiv_gate
// Programmable, glitch-free clock divider and gate.
// X feeds the A pin of a clkbuf_8.
// The output period is 2*(D+1) CLK cycles with a 50% duty cycle.
// Start, stop and ratio changes only take effect on whole-period boundaries.
// A period runs from one 1->0 edge of X to the next 1->0 edge.
//
// Ports
//   CLK     in   source clock, rising-edge active
//   RESETB  in   asynchronous active-low reset
//   EN      in   run request, synchronous to CLK
//   D       in   [DIV_W] division select
//   X       out  divided clock, straight from a flop
//   BUSY    out  registered, high whenever the divider is not idle
//   TICK    out  registered, high for the cycle in which X first reads high
//   vpwr/vgnd/vpb/vnb  in  power pins, present only with SC_USE_PG_PIN;
//                          otherwise they are local supply nets
// -----------------------------------------------------------------------------
module scs8hd_clkdiv_gate #(
  parameter int unsigned DIV_W = 4
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             EN,
  input  logic [DIV_W-1:0] D,
  output logic             X,
  output logic             BUSY,
  output logic             TICK
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply1 vpb;
  supply0 vgnd;
  supply0 vnb;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // A dead supply holds the block in reset; with plain supply nets this is RESETB
  logic pg_ok_c;
  logic rst_n;
  assign pg_ok_c = vpwr & vpb & ~vgnd & ~vnb;
  assign rst_n   = RESETB & pg_ok_c;

  state_e           state_q, state_d;
  logic             x_q, x_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] d_act_q, d_act_d;
  logic             at_end_c;

  // Current half-period is complete on this edge
  assign at_end_c = (cnt_q == d_act_q);

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      d_act_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      d_act_q <= d_act_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    d_act_d = d_act_q;
    tick_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        x_d   = 1'b0;
        cnt_d = '0;
        if (EN) begin
          state_d = ST_RUN;
          d_act_d = D;
        end
      end

      ST_RUN, ST_STOP: begin
        if ((state_q == ST_STOP) && !EN && at_end_c) begin
          // Stop lands on a boundary.
          // This is either the end of a high phase, or a rise that must not happen.
          state_d = ST_IDLE;
          x_d     = 1'b0;
          cnt_d   = '0;
        end else begin
          // EN high in STOP resumes without disturbing the count.
          state_d = EN ? ST_RUN : ST_STOP;
          if (at_end_c) begin
            x_d    = ~x_q;
            cnt_d  = '0;
            tick_d = ~x_q;
            // The 1->0 edge opens a new period, so the new ratio is taken here.
            if (x_q) begin
              d_act_d = D;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        x_d     = 1'b0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign X    = x_q;
  assign BUSY = busy_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_scs8hd_clkdiv_gate.sv
// -----------------------------------------------------------------------------
// tb_scs8hd_clkdiv_gate
// Self-checking bench for scs8hd_clkdiv_gate.
// It uses a vector table, directed corner sequences and randomized stimulus.
// A phase-length reference model checks every clock.
// -----------------------------------------------------------------------------
module tb_scs8hd_clkdiv_gate;

  localparam int unsigned DIV_W = 4;

  logic             CLK = 1'b0;
  logic             RESETB;
  logic             EN;
  logic [DIV_W-1:0] D;
  logic             X;
  logic             BUSY;
  logic             TICK;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  scs8hd_clkdiv_gate #(.DIV_W(DIV_W)) dut (
`ifdef SC_USE_PG_PIN
    .vpwr   (1'b1),
    .vgnd   (1'b0),
    .vpb    (1'b1),
    .vnb    (1'b0),
`endif
    .CLK    (CLK),
    .RESETB (RESETB),
    .EN     (EN),
    .D      (D),
    .X      (X),
    .BUSY   (BUSY),
    .TICK   (TICK)
  );

  // Reference model.
  // It tracks how long the current phase has lasted against its required length.
  bit m_active;
  bit m_stop;
  bit m_x;
  bit m_tick;
  int m_pos;
  int m_len;

  task automatic model_reset();
    m_active = 1'b0;
    m_stop   = 1'b0;
    m_x      = 1'b0;
    m_tick   = 1'b0;
    m_pos    = 0;
    m_len    = 1;
  endtask

  task automatic model_edge(input logic en, input logic [DIV_W-1:0] d);
    m_tick = 1'b0;
    if (!m_active) begin
      m_x = 1'b0;
      if (en) begin
        m_active = 1'b1;
        m_stop   = 1'b0;
        m_len    = int'(d) + 1;
        m_pos    = 0;
      end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == m_len) begin
        m_pos = 0;
        if (m_stop && !en) begin
          m_active = 1'b0;
          m_x      = 1'b0;
        end else begin
          if (m_x) m_len = int'(d) + 1;
          else     m_tick = 1'b1;
          m_x = !m_x;
        end
      end
      if (m_active) m_stop = !en;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge, advance the model, then compare away from the edge
  task automatic step();
    @(posedge CLK);
    if (RESETB) model_edge(EN, D);
    else        model_reset();
    #1;
    check("model", 8'({X, BUSY, TICK}), 8'({m_x, m_active, m_tick}));
  endtask

  // Number of edges until X leaves level lvl (bounded)
  task automatic run_phase(input logic lvl, output int len);
    len = 0;
    while (X === lvl && len < 200) begin
      step();
      len++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    EN = 1'b0;
    while (BUSY !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check("reach_idle", 8'({X, BUSY}), 8'(2'b00));
  endtask

  typedef struct {
    logic             en;
    logic [DIV_W-1:0] d;
    logic             x;
    logic             busy;
    logic             tick;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int len;
    int ticks;

    // {EN, D, X, BUSY, TICK} after each edge, starting from idle
    // Divide by 2, then stop right after a rise
    vecs[0]  = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    // D=2, EN dropped mid-high phase
    vecs[7]  = '{1'b1, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'd2, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'd2, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    // D=1, EN dropped on the 1->0 edge: a full low phase precedes idle
    vecs[15] = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0};

    model_reset();
    RESETB = 1'b0;
    EN     = 1'b1;
    D      = 4'd5;

    // Reset holds everything low even with EN high
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", 8'({X, BUSY, TICK}), 8'(3'b000));
    end
    RESETB = 1'b1;
    EN     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_x", 8'({X, BUSY, TICK}), 8'(3'b000));
    end

    // Vector table
    for (int i = 0; i < 22; i++) begin
      EN = vecs[i].en;
      D  = vecs[i].d;
      step();
      check($sformatf("vec%0d", i), 8'({X, BUSY, TICK}),
            8'({vecs[i].x, vecs[i].busy, vecs[i].tick}));
    end

    // Divide by 2: rise one edge after start, 10 ticks in 20 cycles
    EN = 1'b1;
    D  = 4'd0;
    step();
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) check("div2_first_rise", 8'(X), 8'(1));
      if (TICK === 1'b1) ticks++;
    end
    check("div2_ticks", 8'(ticks), 8'(10));
    wait_idle();

    // Max ratio: 16 low before first rise, then 16 high / 16 low
    EN = 1'b1;
    D  = 4'd15;
    step();
    run_phase(1'b0, len); check("max_first_low", 8'(len), 8'(16));
    run_phase(1'b1, len); check("max_high",      8'(len), 8'(16));
    run_phase(1'b0, len); check("max_low",       8'(len), 8'(16));
    wait_idle();

    // Ratio change mid high phase.
    // The high phase keeps its length; the new ratio starts at the 1->0 edge.
    EN = 1'b1;
    D  = 4'd3;
    step();
    run_phase(1'b0, len); check("chg_first_low", 8'(len), 8'(4));
    step();
    D = 4'd1;
    run_phase(1'b1, len); check("chg_high_rest", 8'(len + 1), 8'(4));
    run_phase(1'b0, len); check("chg_low_new",   8'(len), 8'(2));
    run_phase(1'b1, len); check("chg_high_new",  8'(len), 8'(2));
    run_phase(1'b0, len); check("chg_low_new2",  8'(len), 8'(2));
    wait_idle();

    // Restart from STOP within one high phase.
    // The waveform must match EN held high: X = (k/3)%2 for D=2.
    EN = 1'b1;
    D  = 4'd2;
    step();
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) EN = 1'b0;
      if (k == 5) EN = 1'b1;
      step();
      check($sformatf("restart_k%0d", k), 8'({X, BUSY}), 8'({1'((k / 3) % 2), 1'b1}));
    end
    wait_idle();

    // Async reset while X is high, no clock edge needed
    EN = 1'b1;
    D  = 4'd2;
    step();
    run_phase(1'b0, len);
    check("arst_pre_high", 8'(X), 8'(1));
    #2;
    RESETB = 1'b0;
    model_reset();
    #1;
    check("arst_immediate", 8'({X, BUSY, TICK}), 8'(3'b000));
    #1;
    RESETB = 1'b1;
    step();
    run_phase(1'b0, len); check("arst_restart_rise", 8'(len), 8'(3));
    wait_idle();

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) EN = ~EN;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) D = 4'($urandom_range(0, 15));
        else                           D = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2;
        RESETB = 1'b0;
        model_reset();
        #2;
        RESETB = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
